adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 172 +++++++++++++++++
 tb/tb_adder_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Two-requester front end sharing one ripple-carry adder through an IDLE/ADD/HOLD FSM.
// Define ROUND_ROBIN_EN for alternating grants; otherwise requester 0 has fixed priority.

module ripple_carry_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [8:0] sum
);
  logic [8:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign sum[8] = carry[8];
endmodule

module adder_arbiter #(
  parameter int ADD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       req1_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] out_sum,
  output logic       out_id
);
  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [1:0] LAST_CNT = 2'(ADD_CYCLES - 1);

  state_t     state, next_state;
  logic [1:0] settle_cnt;
  logic [7:0] op_a, op_b;
  logic       op_id;
  logic [8:0] adder_sum;
  logic       grant_id;
  logic       accept;

  // The adder only ever sees the operand registers, so it settles on stable inputs.
  ripple_carry_adder u_adder (
    .a   (op_a),
    .b   (op_b),
    .sum (adder_sum)
  );

`ifdef ROUND_ROBIN_EN
  logic rr_ptr;

  always_comb begin
    if (req0_valid && req1_valid) begin
      grant_id = ~rr_ptr;
    end else begin
      grant_id = req1_valid;
    end
  end

  // Pointer remembers the last granted requester and moves only on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (accept) begin
      rr_ptr <= grant_id;
    end
  end
`else
  assign grant_id = req1_valid & ~req0_valid;
`endif

  assign accept = (state == IDLE) && (req0_valid || req1_valid) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = ADD;
        end else begin
          next_state = IDLE;
        end
      end
      ADD: begin
        if (settle_cnt == LAST_CNT) begin
          next_state = HOLD;
        end else begin
          next_state = ADD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          next_state = IDLE;
        end else begin
          next_state = HOLD;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (accept) begin
      req0_ready = ~grant_id;
      req1_ready = grant_id;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= 2'd0;
      op_a       <= 8'd0;
      op_b       <= 8'd0;
      op_id      <= 1'b0;
      out_valid  <= 1'b0;
      out_sum    <= 9'd0;
      out_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          settle_cnt <= 2'd0;
          if (accept) begin
            op_a  <= grant_id ? req1_a : req0_a;
            op_b  <= grant_id ? req1_b : req0_b;
            op_id <= grant_id;
          end
        end
        ADD: begin
          if (settle_cnt == LAST_CNT) begin
            settle_cnt <= 2'd0;
            out_sum    <= adder_sum;
            out_id     <= op_id;
            out_valid  <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 2'd1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          settle_cnt <= 2'd0;
          out_valid  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: one default instance and one with ADD_CYCLES=4.
module tb_adder_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       out_valid, out_ready, out_id;
  logic [8:0] out_sum;

  logic       d4_req0_valid, d4_req1_valid, d4_req0_ready, d4_req1_ready;
  logic [7:0] d4_req0_a, d4_req0_b, d4_req1_a, d4_req1_b;
  logic       d4_out_valid, d4_out_ready, d4_out_id;
  logic [8:0] d4_out_sum;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  adder_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_id(out_id)
  );

  adder_arbiter #(.ADD_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(d4_req0_valid), .req0_a(d4_req0_a), .req0_b(d4_req0_b), .req0_ready(d4_req0_ready),
    .req1_valid(d4_req1_valid), .req1_a(d4_req1_a), .req1_b(d4_req1_b), .req1_ready(d4_req1_ready),
    .out_valid(d4_out_valid), .out_ready(d4_out_ready), .out_sum(d4_out_sum), .out_id(d4_out_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-requester transaction with out_ready high; checks the exact latency.
  task automatic run_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                        input logic [8:0] exp_sum);
    out_ready = 1'b1;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
    #1;
    chk("op_ready_granted", id ? req1_ready : req0_ready, 1);
    chk("op_ready_other", id ? req0_ready : req1_ready, 0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("op_valid_n1", out_valid, 0);
    step();
    chk("op_valid_n2", out_valid, 1);
    chk("op_sum", out_sum, exp_sum);
    chk("op_id", out_id, id);
    step();
    chk("op_valid_after", out_valid, 0);
  endtask

  initial begin
    logic [0:3] rr_ids;
    logic [8:0] exp_s;
    int w;
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 8'd1; req0_b = 8'd2; req1_a = 8'd3; req1_b = 8'd4;
    out_ready = 1'b0;
    d4_req0_valid = 1'b0; d4_req1_valid = 1'b0;
    d4_req0_a = 8'd0; d4_req0_b = 8'd0; d4_req1_a = 8'd0; d4_req1_b = 8'd0;
    d4_out_ready = 1'b0;
    step();
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_id", out_id, 0);
    step();
    chk("rst_ready0_b", req0_ready, 0);
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    run_op(1'b0, 8'd5, 8'd10, 9'd15);
    run_op(1'b1, 8'd255, 8'd1, 9'd256);
    run_op(1'b0, 8'd128, 8'd128, 9'd256);

    // Backpressure on requester 1; a new valid during HOLD must be ignored.
    out_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 8'd50; req1_b = 8'd25;
    #1;
    chk("bp_accept", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    step();
    req1_valid = 1'b1; req1_a = 8'd9; req1_b = 8'd9;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", out_sum, 75);
      chk("bp_no_ready", {req0_ready, req1_ready}, 0);
      step();
    end
    req1_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release", out_valid, 0);
    chk("bp_sum_kept", out_sum, 75);

    // Contention: last grant was requester 1, so round robin starts at 0.
`ifdef ROUND_ROBIN_EN
    rr_ids = 4'b0101;
`else
    rr_ids = 4'b0000;
`endif
    req0_valid = 1'b1; req0_a = 8'd100; req0_b = 8'd200;
    req1_valid = 1'b1; req1_a = 8'd0; req1_b = 8'd0;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (!out_valid && w < 10) begin
        chk("ctn_exclusive", req0_ready & req1_ready, 0);
        step();
        w++;
      end
      chk("ctn_timeout", out_valid, 1);
      exp_s = rr_ids[k] ? 9'd0 : 9'd300;
      chk("ctn_id", out_id, rr_ids[k]);
      chk("ctn_sum", out_sum, exp_s);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    step();

    // Reset during ADD discards the operation and clears outputs.
    run_op(1'b1, 8'd255, 8'd1, 9'd256);
    req0_valid = 1'b1; req0_a = 8'd5; req0_b = 8'd10;
    #1;
    chk("rm_accept", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rm_valid", out_valid, 0);
    chk("rm_sum", out_sum, 0);
    chk("rm_id", out_id, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rm_no_valid", out_valid, 0);
    end
    run_op(1'b0, 8'd5, 8'd10, 9'd15);

    // ADD_CYCLES=4 instance: acceptance at N gives out_valid at N+5.
    d4_out_ready = 1'b1;
    d4_req0_valid = 1'b1; d4_req0_a = 8'd7; d4_req0_b = 8'd9;
    #1;
    chk("d4_accept", d4_req0_ready, 1);
    step();
    d4_req0_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("d4_not_yet", d4_out_valid, 0);
      step();
    end
    chk("d4_valid", d4_out_valid, 1);
    chk("d4_sum", d4_out_sum, 16);
    chk("d4_id", d4_out_id, 0);
    step();
    chk("d4_done", d4_out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
